// File: rtl/cond_pkg.sv
// Condition-code encodings, NZCV bit positions and the shared condition evaluator.
// Pure combinational helpers; no latency, no flow control.
// Imported by the status unit and its per-lane evaluator.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond,
                                       input logic [3:0] nzcv,
                                       input logic       nv_pass);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        r = 1'b0;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = nv_pass;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_eval_lane.sv
// Per-lane condition evaluator.
// Combinational, zero latency.
// No flow control; the caller qualifies the result with its own accept.
module cond_eval_lane
    import cond_pkg::*;
#(
    parameter bit NV_PASS = 1'b0
) (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    assign pass = cond_eval(cond, nzcv, NV_PASS);

endmodule

// File: rtl/cond_status_unit.sv
// NZCV status register owner and multi-lane condition evaluator with in-flight writer tracking.
// Response latency exactly one cycle after accept; responses cannot be back-pressured.
// All lanes stall together (req_ready low) while any flag-setter is in flight and flags are not final.
module cond_status_unit
    import cond_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned MAX_PENDING = 3,
    parameter bit          BYPASS      = 1'b1,
    parameter bit          NV_PASS     = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             set_issue,
    output logic                             set_ready,
    input  logic                             wb_valid,
    input  logic [3:0]                       wb_status,
    input  logic [LANES-1:0]                 req_valid,
    input  logic [4*LANES-1:0]               req_cond,
    output logic [LANES-1:0]                 req_ready,
    output logic [LANES-1:0]                 resp_valid,
    output logic [LANES-1:0]                 resp_pass,
    output logic [3:0]                       status,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             proto_err
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    logic             issue_acc;
    logic             use_bypass;
    logic             clean;
    logic [3:0]       src;
    logic [LANES-1:0] accept;
    logic [LANES-1:0] lane_pass;

    assign set_ready = (pending < PW'(MAX_PENDING));
    assign issue_acc = set_issue & set_ready;

    // Last writer retiring with no new writer behind it: its flags are final this cycle.
    assign use_bypass = BYPASS && wb_valid && (pending == PW'(1)) && !set_issue;
    assign clean      = (pending == '0) || use_bypass;
    assign src        = use_bypass ? wb_status : status;

    assign req_ready = {LANES{clean}};
    assign accept    = req_valid & req_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_eval_lane #(
            .NV_PASS (NV_PASS)
        ) u_lane (
            .cond (req_cond[4*i +: 4]),
            .nzcv (src),
            .pass (lane_pass[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status     <= '0;
            pending    <= '0;
            resp_valid <= '0;
            resp_pass  <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (wb_valid) begin
                status <= wb_status;
            end
            if (issue_acc && !wb_valid) begin
                pending <= pending + PW'(1);
            end else if (wb_valid && !issue_acc && (pending != '0)) begin
                pending <= pending - PW'(1);
            end
            if (wb_valid && (pending == '0)) begin
                proto_err <= 1'b1;
            end
            resp_valid <= accept;
            resp_pass  <= (accept & lane_pass) | (~accept & resp_pass);
        end
    end

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed bench for cond_status_unit: two instances (bypass/NV-fail and no-bypass/NV-pass)
// share stimulus; table vectors plus hand-written multi-cycle sequences and a full cond x NZCV sweep.
`timescale 1ns/1ps
module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_issue;
    logic       wb_valid;
    logic [3:0] wb_status;
    logic [1:0] req_valid;
    logic [7:0] req_cond;

    logic       set_ready_a, set_ready_b;
    logic [1:0] req_ready_a, req_ready_b;
    logic [1:0] resp_valid_a, resp_valid_b;
    logic [1:0] resp_pass_a, resp_pass_b;
    logic [3:0] status_a, status_b;
    logic [1:0] pending_a, pending_b;
    logic       proto_err_a, proto_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cond_status_unit #(.LANES(2), .MAX_PENDING(3), .BYPASS(1'b1), .NV_PASS(1'b0)) dut_a (
        .clk(clk), .rst(rst), .set_issue(set_issue), .set_ready(set_ready_a),
        .wb_valid(wb_valid), .wb_status(wb_status), .req_valid(req_valid), .req_cond(req_cond),
        .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_pass(resp_pass_a),
        .status(status_a), .pending(pending_a), .proto_err(proto_err_a));

    cond_status_unit #(.LANES(2), .MAX_PENDING(3), .BYPASS(1'b0), .NV_PASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .set_issue(set_issue), .set_ready(set_ready_b),
        .wb_valid(wb_valid), .wb_status(wb_status), .req_valid(req_valid), .req_cond(req_cond),
        .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_pass(resp_pass_b),
        .status(status_b), .pending(pending_b), .proto_err(proto_err_b));

    typedef struct {
        logic [3:0] nzcv;
        logic [1:0] rv;
        logic [7:0] cond;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    vec_t vecs[8];

    // Reference built from the ARM encoding structure: cond[3:1] picks the test, cond[0] inverts it.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f, input logic nvp);
        logic n, z, cf, v, b;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cf;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cf & ~z;
            3'd5:    b = (n == v);
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return nvp;
        return b ^ c[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic load_status(input logic [3:0] s);
        set_issue = 1'b1;
        tick();
        set_issue = 1'b0;
        wb_valid  = 1'b1;
        wb_status = s;
        tick();
        wb_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //         nzcv     rv     cond   exp_a  exp_b
        vecs[0] = '{4'b0110, 2'b11, 8'h80, 2'b01, 2'b01};  // EQ / HI with Z,C
        vecs[1] = '{4'b0110, 2'b10, 8'h91, 2'b11, 2'b11};  // lane1 LS only, lane0 holds
        vecs[2] = '{4'b1001, 2'b11, 8'hBA, 2'b01, 2'b01};  // GE / LT, N==V
        vecs[3] = '{4'b1000, 2'b11, 8'hDC, 2'b10, 2'b10};  // GT / LE, N!=V
        vecs[4] = '{4'b0010, 2'b11, 8'h32, 2'b01, 2'b01};  // CS / CC
        vecs[5] = '{4'b0001, 2'b11, 8'h76, 2'b01, 2'b01};  // VS / VC
        vecs[6] = '{4'b0000, 2'b11, 8'hE5, 2'b11, 2'b11};  // PL / AL
        vecs[7] = '{4'b0000, 2'b11, 8'h4F, 2'b00, 2'b01};  // NV / MI

        rst = 1'b1; set_issue = 1'b0; wb_valid = 1'b0; wb_status = '0;
        req_valid = '0; req_cond = '0;
        tick(); tick();
        rst = 1'b0;

        // Stray writeback first so reset has sticky state to clear.
        wb_valid = 1'b1; wb_status = 4'b1010;
        tick();
        wb_valid = 1'b0;
        check("stray_wb_status", status_a, 4'b1010);
        check("stray_wb_proto_err", proto_err_a, 1'b1);

        // Request alongside issue sees pre-issue state: MI on 1010 passes, EQ fails.
        set_issue = 1'b1; req_valid = 2'b11; req_cond = 8'h04;
        mid();
        check("issue_cycle_req_ready", req_ready_a, 2'b11);
        tick();
        check("issue_cycle_resp_valid", resp_valid_a, 2'b11);
        check("issue_cycle_resp_pass", resp_pass_a, 2'b01);
        check("issue_cycle_pending", pending_a, 2'd1);
        mid();
        check("pending1_req_ready", req_ready_a, 2'b00);
        tick();
        check("pending2", pending_a, 2'd2);
        check("stalled_resp_valid", resp_valid_a, 2'b00);
        check("stalled_resp_pass_hold", resp_pass_a, 2'b01);

        rst = 1'b1;
        tick();
        rst = 1'b0; set_issue = 1'b0; req_valid = '0;
        check("rst_pending", pending_a, 2'd0);
        check("rst_status", status_a, 4'b0000);
        check("rst_resp_valid", resp_valid_a, 2'b00);
        check("rst_resp_pass", resp_pass_a, 2'b00);
        check("rst_proto_err", proto_err_a, 1'b0);
        check("rst_set_ready", set_ready_a, 1'b1);

        foreach (vecs[k]) begin
            load_status(vecs[k].nzcv);
            req_valid = vecs[k].rv;
            req_cond  = vecs[k].cond;
            tick();
            req_valid = '0;
            check($sformatf("vec%0d_resp_valid_a", k), resp_valid_a, vecs[k].rv);
            check($sformatf("vec%0d_resp_pass_a", k), resp_pass_a, vecs[k].exp_a);
            check($sformatf("vec%0d_resp_valid_b", k), resp_valid_b, vecs[k].rv);
            check($sformatf("vec%0d_resp_pass_b", k), resp_pass_b, vecs[k].exp_b);
        end

        // Stall until writeback; GE on 1000 fails.
        set_issue = 1'b1;
        tick();
        set_issue = 1'b0; req_valid = 2'b01; req_cond = 8'h0A;
        mid();
        check("stall_ready_a", req_ready_a, 2'b00);
        check("stall_ready_b", req_ready_b, 2'b00);
        tick();
        check("stall_resp_valid_a", resp_valid_a, 2'b00);
        wb_valid = 1'b1; wb_status = 4'b1000;
        mid();
        check("bypass_ready_a", req_ready_a, 2'b11);
        check("nobypass_ready_b", req_ready_b, 2'b00);
        tick();
        wb_valid = 1'b0;
        check("bypass_resp_valid_a", resp_valid_a, 2'b01);
        check("bypass_resp_pass_a", resp_pass_a, 2'b00);
        check("nobypass_resp_valid_b_early", resp_valid_b, 2'b00);
        check("after_wb_pending", pending_a, 2'd0);
        check("after_wb_status", status_a, 4'b1000);
        mid();
        check("nobypass_ready_b_late", req_ready_b, 2'b11);
        tick();
        req_valid = '0;
        check("nobypass_resp_valid_b", resp_valid_b, 2'b01);
        check("nobypass_resp_pass_b", resp_pass_b, 2'b00);

        // Saturation.
        set_issue = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("sat_pending_%0d", i), pending_a, i);
        end
        mid();
        check("sat_set_ready", set_ready_a, 1'b0);
        tick();
        check("sat_ignored_issue", pending_a, 2'd3);
        set_issue = 1'b0; wb_valid = 1'b1; wb_status = 4'b0101;
        tick();
        check("sat_wb_dec", pending_a, 2'd2);
        set_issue = 1'b1;
        mid();
        check("sat_set_ready_again", set_ready_a, 1'b1);
        tick();
        check("issue_wb_same_cycle", pending_a, 2'd2);
        set_issue = 1'b0;
        tick(); tick();
        wb_valid = 1'b0;
        check("drain_pending", pending_a, 2'd0);
        check("drain_status", status_a, 4'b0101);
        check("drain_no_proto_err", proto_err_a, 1'b0);

        // Protocol error.
        wb_valid = 1'b1; wb_status = 4'b0001;
        tick();
        wb_valid = 1'b0;
        check("perr_status", status_a, 4'b0001);
        check("perr_pending", pending_a, 2'd0);
        check("perr_flag_a", proto_err_a, 1'b1);
        check("perr_flag_b", proto_err_b, 1'b1);
        tick();
        check("perr_sticky", proto_err_a, 1'b1);
        check("perr_pending_hold", pending_a, 2'd0);

        // Full sweep: lane0 cond c, lane1 cond 15-c.
        for (int f = 0; f < 16; f++) begin
            load_status(4'(f));
            for (int c = 0; c < 16; c++) begin
                req_valid = 2'b11;
                req_cond  = {4'(15 - c), 4'(c)};
                tick();
                check($sformatf("sweep_a_f%0d_c%0d", f, c), resp_pass_a,
                      {ref_eval(4'(15 - c), 4'(f), 1'b0), ref_eval(4'(c), 4'(f), 1'b0)});
                check($sformatf("sweep_b_f%0d_c%0d", f, c), resp_pass_b,
                      {ref_eval(4'(15 - c), 4'(f), 1'b1), ref_eval(4'(c), 4'(f), 1'b1)});
            end
            req_valid = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
